atom_tape_player: RTL and testbench

- Cassette encoder. Turns a byte stream, e.g. from a RAM-buffered downloaded tape image, into an Atom CUTS 300-baud tone signal.
- cas_out is muxed in front of the core's cas_in, in place of the ADC tape decoder output.
- It is the transmit/playback end of the Atom cassette interface that the core's tape input decodes.
- Frame: start bit 0, 8 data bits LSB-first, STOP_BITS stop bits of 1. Bit 0 = 4 cycles of 1200 Hz; bit 1 = 8 cycles of 2400 Hz.

---
 rtl/atom_tape_pkg.sv | 21 ++
 rtl/atom_tape_tick.sv | 37 +++
 rtl/atom_tape_player.sv | 106 ++++++++++
 tb/tb_atom_tape_player.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/atom_tape_pkg.sv
// Shared types and constants for the Atom CUTS 300-baud tape player.
package atom_tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEADER,
        START,
        DATA,
        STOP,
        MARK
    } state_t;

    localparam int TICKS_PER_BIT = 16;
    localparam int TONE_HZ_BASE  = 4800;

    // Prescaler terminal count for a 4800 Hz tick (two ticks per 2400 Hz cycle).
    function automatic int tick_div(input int clk_hz);
        return clk_hz / TONE_HZ_BASE;
    endfunction

endpackage

// File: rtl/atom_tape_tick.sv
// 4800 Hz tick prescaler plus the 16-tick bit-time counter of the tape player.
module atom_tape_tick
    import atom_tape_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick2,
    output logic bit_end
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic [3:0]    tick_cnt;

    assign tick    = (pre_cnt == PW'(TICK_DIV - 1));
    // Every second tick of a bit: the half-period edge of the 1200 Hz tone.
    assign tick2   = tick && tick_cnt[0];
    assign bit_end = tick && (tick_cnt == 4'(TICKS_PER_BIT - 1));

    always_ff @(posedge clk_sys) begin
        if (reset || clear) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick) begin
            pre_cnt  <= '0;
            tick_cnt <= tick_cnt + 4'd1;
        end else begin
            pre_cnt  <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/atom_tape_player.sv
// Byte stream to Atom CUTS tape tone encoder: leader, then start/8 data/stop frames.
module atom_tape_player
    import atom_tape_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int LEADER_BITS = 600,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       cas_out,
    output logic       active,
    output logic       underrun
);

    localparam int TICK_DIV = tick_div(CLK_HZ);

    state_t      state;
    logic [15:0] bit_cnt;
    logic [7:0]  shift;
    logic        seen_byte;

    logic tick;
    logic tick2;
    logic bit_end;
    logic prescale_clear;
    logic last_bit;
    logic boundary;
    logic space_bit;

    assign prescale_clear = (state == IDLE) || !enable;

    atom_tape_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (prescale_clear),
        .tick    (tick),
        .tick2   (tick2),
        .bit_end (bit_end)
    );

    assign last_bit  = (bit_cnt == 16'd1);
    assign boundary  = bit_end && (((state == LEADER || state == STOP) && last_bit)
                                   || state == MARK);
    assign s_ready   = boundary && enable && !reset;
    assign active    = (state != IDLE);
    assign space_bit = (state == START) || (state == DATA && !shift[0]);

    // NOTE: all state here is updated with <= so every branch reads the pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            seen_byte <= 1'b0;
            underrun  <= 1'b0;
            cas_out   <= 1'b0;
        end else if (!enable) begin
            state   <= IDLE;
            cas_out <= 1'b0;
        end else if (state == IDLE) begin
            state     <= LEADER;
            bit_cnt   <= 16'(LEADER_BITS);
            seen_byte <= 1'b0;
            underrun  <= 1'b0;
            cas_out   <= 1'b1;
        end else if (bit_end) begin
            // Each bit is whole tone cycles, so every bit starts high.
            cas_out <= 1'b1;
            case (state)
                LEADER, STOP: if (!last_bit) bit_cnt <= bit_cnt - 16'd1;
                START: begin
                    state   <= DATA;
                    bit_cnt <= 16'd8;
                end
                DATA: begin
                    shift <= shift >> 1;
                    if (last_bit) begin
                        state   <= STOP;
                        bit_cnt <= 16'(STOP_BITS);
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
            if (boundary) begin
                if (s_valid) begin
                    state     <= START;
                    shift     <= s_data;
                    seen_byte <= 1'b1;
                end else begin
                    state <= MARK;
                    if (seen_byte) underrun <= 1'b1;
                end
            end
        end else if (space_bit ? tick2 : tick) begin
            cas_out <= !cas_out;
        end
    end

endmodule

// File: tb/tb_atom_tape_player.sv
// Directed bench for atom_tape_player: TICK_DIV=10, 160-clock bits, 2-bit leader, 1 stop bit.
module tb_atom_tape_player;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       enable  = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       cas_out;
    logic       active;
    logic       underrun;

    int vectors     = 0;
    int miscompares = 0;
    int n;
    logic seen;

    atom_tape_player #(
        .CLK_HZ      (48000),
        .LEADER_BITS (2),
        .STOP_BITS   (1)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .enable   (enable),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .cas_out  (cas_out),
        .active   (active),
        .underrun (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ready(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget) begin
            step(1);
            cnt++;
            if (s_ready) break;
        end
    endtask

    // Entered one cycle before the accepting edge A; walks the frame and ends at A+1599.
    task automatic play_char(input logic [7:0] data, input logic [7:0] nxt_data,
                             input logic nxt_valid);
        int   pos;
        int   t;
        logic b;
        logic exp;
        step(1);
        pos     = 0;
        s_data  = nxt_data;
        s_valid = nxt_valid;
        for (int bi = 0; bi < 10; bi++) begin
            b = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : data[bi-1];
            for (int k = 0; k < 4; k++) begin
                t = 5 + 10 * k;
                step(bi * 160 + t - pos);
                pos = bi * 160 + t;
                // Mark: 10-clock half periods; space: 20-clock half periods.
                exp = b ? (((t / 10) % 2) == 0) : (((t / 20) % 2) == 0);
                check($sformatf("cas_%02h_bit%0d_t%0d", data, bi, t), cas_out, exp);
                if (k == 0) check("ready_mid_char", s_ready, 1'b0);
            end
        end
        check("active_char", active, 1'b1);
        step(1599 - pos);
        check("ready_next_boundary", s_ready, 1'b1);
    endtask

    initial begin
        step(3);
        check("rst_cas", cas_out, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_underrun", underrun, 1'b0);

        reset = 1'b0;
        step(50);
        check("idle_cas", cas_out, 1'b0);
        check("idle_active", active, 1'b0);
        check("idle_ready", s_ready, 1'b0);

        // Leader latency with s_valid already high during the leader.
        s_data  = 8'h55;
        s_valid = 1'b1;
        enable  = 1'b1;
        wait_ready(2000, n);
        check("leader_latency", n, 320);
        check("active_leader", active, 1'b1);
        check("underrun_start", underrun, 1'b0);

        play_char(8'h55, 8'h00, 1'b1);
        play_char(8'h00, 8'hFF, 1'b1);
        check("no_underrun_b2b", underrun, 1'b0);
        play_char(8'hFF, 8'h00, 1'b0);

        // Underrun: one idle mark bit, then the next byte is taken 160 cycles after the boundary.
        step(1);
        check("underrun_set", underrun, 1'b1);
        check("ready_after_boundary", s_ready, 1'b0);
        step(15);
        check("mark_t15", cas_out, 1'b0);
        step(10);
        check("mark_t25", cas_out, 1'b1);
        s_data  = 8'hA3;
        s_valid = 1'b1;
        wait_ready(2000, n);
        check("mark_gap", n, 134);

        // Drop enable at clock 80 of data bit 3.
        step(720);
        enable = 1'b0;
        s_data = 8'h11;
        step(1);
        check("stop_cas", cas_out, 1'b0);
        check("stop_active", active, 1'b0);
        seen = 1'b0;
        repeat (500) begin
            step(1);
            if (s_ready) seen = 1'b1;
        end
        check("no_ready_disabled", seen, 1'b0);
        check("underrun_sticky", underrun, 1'b1);

        enable = 1'b1;
        s_data = 8'h3C;
        wait_ready(2000, n);
        check("releader_latency", n, 320);
        check("underrun_cleared", underrun, 1'b0);

        // enable low on the boundary cycle wins over the handshake.
        enable = 1'b0;
        #1;
        check("ready_gated", s_ready, 1'b0);
        step(1);
        check("gated_idle", active, 1'b0);

        s_data = 8'h96;
        enable = 1'b1;
        wait_ready(2000, n);
        check("third_leader", n, 320);
        play_char(8'h96, 8'h81, 1'b1);

        // Reset in the middle of a data bit.
        step(400);
        reset = 1'b1;
        step(1);
        check("midrst_cas", cas_out, 1'b0);
        check("midrst_active", active, 1'b0);
        check("midrst_ready", s_ready, 1'b0);
        check("midrst_underrun", underrun, 1'b0);
        reset  = 1'b0;
        enable = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
